// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//   Types and constants shared by the handshaked 1-to-4 demultiplexer and its
//   destination decoder.
//   - state_e : handshake FSM states, 2-bit encoding
//   - CH0..CH3: channel (destination code) indices
// -----------------------------------------------------------------------------
package demux_pkg;

  typedef enum logic [1:0] {
    ACCEPT   = 2'b00,  // ready for a producer word
    WAIT_REL = 2'b01,  // word latched, waiting for the producer to drop dav_in
    WAIT_RFD = 2'b10,  // waiting for the selected consumer to be ready
    SEND     = 2'b11   // dav_out raised, waiting for the consumer to take it
  } state_e;

  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;

endpackage : demux_pkg

// File: rtl/decoder_2_to_4.sv
// -----------------------------------------------------------------------------
// decoder_2_to_4
//   Combinational 2-to-4 decoder: turns a destination code into a one-hot
//   channel select.
//   Ports:
//     sel_i    in  2  destination code {b1,b0}
//     onehot_o out 4  one-hot select, bit p set for code p
// -----------------------------------------------------------------------------
module decoder_2_to_4
  import demux_pkg::*;
(
  input  logic [1:0] sel_i,
  output logic [3:0] onehot_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    onehot_o = 4'b0000;
    unique case (sel_i)
      CH0: onehot_o = 4'b0001;
      CH1: onehot_o = 4'b0010;
      CH2: onehot_o = 4'b0100;
      CH3: onehot_o = 4'b1000;
      default: onehot_o = 4'b0000;
    endcase
  end

endmodule : decoder_2_to_4

// File: rtl/demux_1_to_4_hs.sv
// -----------------------------------------------------------------------------
// demux_1_to_4_hs
//   Registered 1-to-4 demultiplexer with four-phase dav/rfd handshakes on both
//   sides. A single word is held in flight: it is captured from the producer,
//   the producer is released, then the word is offered to the consumer named by
//   the captured destination code. A per-channel counter records completed
//   deliveries (wrapping modulo 2^CW).
//   Ports:
//     clock        in  1   system clock, rising edge
//     reset        in  1   synchronous, active-high reset
//     x            in  W   producer data word
//     b1, b0       in  1   destination code MSB / LSB
//     dav_in       in  1   producer data-available
//     rfd_out      out 1   ready-for-data to producer
//     z            out W   registered data word, shared by all consumers
//     dav_out      out 4   per-consumer data-available (at most one set)
//     rfd_in       in  4   per-consumer ready-for-data
//     busy         out 1   high in every state except ACCEPT
//     cnt0..cnt3   out CW  completed deliveries per channel
// -----------------------------------------------------------------------------
module demux_1_to_4_hs
  import demux_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [W-1:0]  x,
  input  logic          b1,
  input  logic          b0,
  input  logic          dav_in,
  output logic          rfd_out,
  output logic [W-1:0]  z,
  output logic [3:0]    dav_out,
  input  logic [3:0]    rfd_in,
  output logic          busy,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3
);

  state_e         state_q, state_d;
  logic [W-1:0]   z_q, z_d;
  logic [1:0]     dest_q, dest_d;
  logic           rfd_out_q, rfd_out_d;
  logic [3:0]     dav_out_q, dav_out_d;
  logic           busy_q, busy_d;
  logic [CW-1:0]  cnt_q [4];

  logic [3:0]     dest_oh;
  logic           deliver;
  logic [3:0]     cnt_inc;

  // One-hot of the latched destination: drives dav_out and picks the counter.
  decoder_2_to_4 u_dest_dec (
    .sel_i    (dest_q),
    .onehot_o (dest_oh)
  );

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    z_d       = z_q;
    dest_d    = dest_q;
    rfd_out_d = rfd_out_q;
    dav_out_d = dav_out_q;
    deliver   = 1'b0;

    unique case (state_q)
      ACCEPT: begin
        if (dav_in) begin
          z_d       = x;
          dest_d    = {b1, b0};
          rfd_out_d = 1'b0;
          state_d   = WAIT_REL;
        end
      end
      WAIT_REL: begin
        // x and {b1,b0} are no longer looked at; only the release matters.
        if (!dav_in) state_d = WAIT_RFD;
      end
      WAIT_RFD: begin
        // Only the selected consumer's rfd is consulted, so a consumer still
        // finishing a previous transfer (rfd low) holds off the next one.
        if (rfd_in[dest_q]) begin
          dav_out_d = dest_oh;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (!rfd_in[dest_q]) begin
          dav_out_d = 4'b0000;
          rfd_out_d = 1'b1;
          deliver   = 1'b1;
          state_d   = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase

    busy_d = (state_d != ACCEPT);
  end

  assign cnt_inc = dest_oh & {4{deliver}};

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ACCEPT;
      z_q       <= '0;
      dest_q    <= CH0;
      rfd_out_q <= 1'b1;
      dav_out_q <= 4'b0000;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      z_q       <= z_d;
      dest_q    <= dest_d;
      rfd_out_q <= rfd_out_d;
      dav_out_q <= dav_out_d;
      busy_q    <= busy_d;
    end
  end

  // NOTE: the counter array is four visible registers, not a storage memory,
  // so each entry is cleared by reset like any other architectural state.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_inc[i]) cnt_q[i] <= cnt_q[i] + CW'(1);
      end
    end
  end

  assign rfd_out = rfd_out_q;
  assign z       = z_q;
  assign dav_out = dav_out_q;
  assign busy    = busy_q;
  assign cnt0    = cnt_q[0];
  assign cnt1    = cnt_q[1];
  assign cnt2    = cnt_q[2];
  assign cnt3    = cnt_q[3];

endmodule : demux_1_to_4_hs

// File: doc/demux_1_to_4_hs.md
Name: demux_1_to_4_hs

Overview:
- Registered, handshaked 1-to-4 demultiplexer: the other direction of the 4-to-1 multiplexer.
- Accepts one W-bit word plus a 2-bit destination code {b1,b0} from a single producer and delivers it to consumer p, where p is the destination code read as an unsigned number.
- Both sides use the four-phase dav/rfd handshake used throughout the codebase's I/O interfaces.
- Sits between a single source (e.g. a CPU output port) and four peripheral consumers.

Parameters:
- W, 8, data word width.
- CW, 8, width of each per-channel delivery counter (wraps modulo 2^CW).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- x  in  W  data word from the producer.
- b1  in  1  destination code, MSB.
- b0  in  1  destination code, LSB.
- dav_in  in  1  producer data-available, active-high.
- rfd_out  out  1  ready-for-data to the producer, active-high.
- z  out  W  registered data word, shared by all four consumers.
- dav_out  out  4  per-consumer data-available; at most one bit set.
- rfd_in  in  4  per-consumer ready-for-data, active-high.
- busy  out  1  high in every state except ACCEPT.
- cnt0, cnt1, cnt2, cnt3  out  CW each  completed deliveries per channel.

Behaviour:
- Reset (clock edge with reset=1), regardless of current state:
  - state=ACCEPT, rfd_out=1, dav_out=0, z=0, dest=0, busy=0, all cnt=0.
  - A transfer in flight is abandoned with no counter update.
- FSM, four states, all outputs registered:
  - ACCEPT: rfd_out=1. On dav_in=1: latch z<=x and dest<={b1,b0}, rfd_out<=0, go to WAIT_REL.
  - WAIT_REL: wait for dav_in=0 (producer release). On dav_in=0, go to WAIT_RFD. b1, b0 and x are ignored after the latch.
  - WAIT_RFD: wait for rfd_in[dest]=1. When seen, dav_out[dest]<=1, go to SEND. rfd_in of other channels is ignored.
  - SEND: hold dav_out[dest]=1 and z stable. On rfd_in[dest]=0 (consumer captured the word):
    - dav_out<=0
    - cnt[dest]<=cnt[dest]+1, modulo 2^CW
    - rfd_out<=1, go to ACCEPT.
- Output-side four-phase rule: dav_out[p] rises only while rfd_in[p]=1 and falls only after rfd_in[p]=0. The consumer must raise rfd_in[p] again before its next transfer; that is checked in WAIT_RFD.
- Latency, minimum edge count:
  - dav_in rise to rfd_out fall: 1 edge.
  - dav_in fall to dav_out[dest] rise: 2 edges, given rfd_in[dest] already 1.
  - rfd_in[dest] fall to rfd_out rise: 1 edge.
- z changes only in ACCEPT on dav_in=1; it holds its last value otherwise, including after delivery.
- No buffering: a single word in flight. rfd_out=0 from capture until delivery completes, so the producer is back-pressured.
- dav_in=1 held continuously after delivery: rfd_out returns to 1 in ACCEPT, and the next edge captures a new word. The producer is responsible for four-phase compliance; the block performs no glitch filtering.
- Counter at 2^CW-1 wraps to 0 on the next delivery to that channel; no flag.
- The idle transition (state ACCEPT, dav_in=0) has no effect.

Decomposition:
- Shared package demux_pkg holds:
  - state enumeration (ACCEPT, WAIT_REL, WAIT_RFD, SEND), 2-bit encoding;
  - channel-index constants CH0..CH3 = 2'b00..2'b11.
- Natural sub-module: decoder_2_to_4, combinational {b1,b0} to one-hot. It is used to form dav_out from dest and to select the counter to increment. The counters stay inline in the top module.

Test Plan:
- Reset mid-SEND: dav_out=4'b0100 when reset=1 for one edge -> next cycle state ACCEPT, rfd_out=1, dav_out=0, z=0, cnt2 unchanged from 0.
- Basic delivery: x=8'hA5, {b1,b0}=2'b10, dav_in pulses, rfd_in=4'b1111:
  - 1 edge later rfd_out=0, z=8'hA5;
  - dav_out=4'b0100 2 edges after dav_in falls;
  - rfd_in[2] drops -> dav_out=0, cnt2=1, rfd_out=1.
- All four channels: send 8'h10, 8'h11, 8'h12, 8'h13 to codes 0..3 -> each word appears on z with the matching one-hot dav_out; final cnt0..cnt3 all 1.
- Slow consumer: rfd_in[1]=0 during WAIT_RFD for 20 cycles, code 2'b01 -> dav_out stays 0, rfd_out stays 0; dav_out=4'b0010 one edge after rfd_in[1] rises. A toggling rfd_in[3] has no effect.
- Input changes during busy: change x and {b1,b0} to 8'hFF/2'b11 while in WAIT_RFD -> z and destination unchanged; cnt3 unchanged.
- Counter wrap with CW=2: five deliveries to channel 0 -> cnt0 sequence 1, 2, 3, 0, 1.
